// File: rtl/tt_um_and_tester.sv
// Two-input gate tester: steps a/b through 00,01,10,11, waits a selectable
// settle time per vector, and compares the synchronized gate output against
// a latched expected function. It reports a per-vector fail mask, a mismatch
// count and a pass flag.
module tt_um_and_tester (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned VEC_W    = 2;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned MASK_W   = 4;
    localparam int unsigned COUNT_W  = 3;
    localparam int unsigned FUNC_W   = 2;
    localparam int unsigned SETTLE_BASE = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    state_e              state_q;
    logic                start_prev_q;
    logic                c_meta_q;
    logic                c_sync_q;
    logic [VEC_W-1:0]    vec_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    settle_q;
    logic [FUNC_W-1:0]   func_q;
    logic                a_q;
    logic                b_q;
    logic [MASK_W-1:0]   mask_q;
    logic [COUNT_W-1:0]  count_q;
    logic                pass_q;

    logic                start_c;
    logic                start_edge_c;
    logic                expected_c;
    logic                mismatch_c;
    logic [VEC_W-1:0]    vec_next_c;
    logic                busy_c;
    logic                done_c;
    logic                unused_inputs;

    // Inputs with no function in this design
    assign unused_inputs = ^{ena, uio_in, ui_in[7:6]};

    assign start_c      = ui_in[0];
    assign start_edge_c = start_c & ~start_prev_q;
    assign vec_next_c   = vec_q + VEC_W'(1);

    // Two-flop synchronizer for the external gate output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_meta_q <= 1'b0;
            c_sync_q <= 1'b0;
        end else begin
            c_meta_q <= ui_in[1];
            c_sync_q <= c_meta_q;
        end
    end

    // Expected gate response for the vector currently driven
    always_comb begin
        expected_c = 1'b0;
        case (func_q)
            2'b00:   expected_c = a_q & b_q;
            2'b01:   expected_c = a_q | b_q;
            2'b10:   expected_c = a_q ^ b_q;
            default: expected_c = ~(a_q & b_q);
        endcase
        mismatch_c = (c_sync_q != expected_c);
    end

    // Sequencer: drive each vector for S cycles, sample once, then advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b1;
            vec_q        <= '0;
            cnt_q        <= '0;
            settle_q     <= CNT_W'(SETTLE_BASE);
            func_q       <= '0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            mask_q       <= '0;
            count_q      <= '0;
            pass_q       <= 1'b0;
        end else begin
            start_prev_q <= start_c;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_edge_c) begin
                        state_q  <= ST_DRIVE;
                        vec_q    <= '0;
                        cnt_q    <= '0;
                        mask_q   <= '0;
                        count_q  <= '0;
                        pass_q   <= 1'b0;
                        settle_q <= CNT_W'(SETTLE_BASE) + CNT_W'(ui_in[3:2]);
                        func_q   <= ui_in[5:4];
                        a_q      <= 1'b0;
                        b_q      <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == settle_q - CNT_W'(1)) begin
                        state_q <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (mismatch_c) begin
                        mask_q[vec_q] <= 1'b1;
                        count_q       <= count_q + COUNT_W'(1);
                    end
                    if (vec_q != VEC_W'(3)) begin
                        state_q <= ST_DRIVE;
                        vec_q   <= vec_next_c;
                        cnt_q   <= '0;
                        a_q     <= vec_next_c[0];
                        b_q     <= vec_next_c[1];
                    end else begin
                        state_q <= ST_DONE;
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                        pass_q  <= (mask_q == '0) && !mismatch_c;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Status flags decoded from registered state
    assign busy_c = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign done_c = (state_q == ST_DONE);

    assign uo_out  = {count_q, pass_q, done_c, busy_c, b_q, a_q};
    assign uio_out = {4'b0000, mask_q};
    assign uio_oe  = 8'h0F;

endmodule

// File: doc/tt_um_and_tester.md
TT_UM_AND_TESTER -- requirements
Module: tt_um_and_tester

Interface
REQ-001 clk  input  1  single clock; all state on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 ena  input  1  always 1 when powered; ignored.
REQ-004 ui_in  input  8  [0] start; [1] c_in, the gate-under-test output; [3:2] settle select; [5:4] expected function (00 AND, 01 OR, 10 XOR, 11 NAND); [7:6] unused.
REQ-005 uo_out  output  8  [0] a drive; [1] b drive; [2] busy; [3] done; [4] pass; [7:5] mismatch count.
REQ-006 uio_in  input  8  unused; ignored.
REQ-007 uio_out  output  8  [3:0] fail mask, one bit per vector {b,a}; [7:4] = 0.
REQ-008 uio_oe  output  8  constant 8'h0F.

Function
REQ-009 c_in SHALL pass through a 2-flop synchronizer before any use; start SHALL be used unsynchronized.
REQ-010 start_prev register SHALL hold the previous cycle's start; a start edge is start=1 and start_prev=0.
REQ-011 FSM states SHALL be IDLE, DRIVE, SAMPLE, DONE.
REQ-012 IDLE or DONE, start edge -> DRIVE: vec=0, cnt=0, mask=0, count=0, pass=0, done=0; latch S = 3 + ui_in[3:2] (range 3..6) and function ui_in[5:4].
REQ-013 DRIVE: a=vec[0], b=vec[1]; cnt increments each cycle; when cnt==S-1 -> SAMPLE. DRIVE SHALL last exactly S cycles.
REQ-014 SAMPLE lasts one cycle, keeps a and b driven, and compares synchronized c against the latched expected function of (a,b).
REQ-015 SAMPLE mismatch: set mask[vec]; increment count (3-bit, maximum 4, no wrap possible).
REQ-016 SAMPLE, vec<3: vec+1, cnt=0 -> DRIVE. SAMPLE, vec==3 -> DONE.
REQ-017 Total run time SHALL be 4*(S+1) cycles; DONE is entered on edge 4*(S+1) after the start-edge sampling edge.
REQ-018 DONE: done=1; pass=1 iff mask==0; mask, count and pass SHALL hold until the next start edge.
REQ-019 In IDLE and DONE, a=b=0; busy=1 exactly in DRIVE and SAMPLE.
REQ-020 Start edges in DRIVE or SAMPLE SHALL be ignored; settle and function changes mid-run SHALL have no effect.
REQ-021 A start held high SHALL NOT retrigger; it requires a low then high transition.
REQ-022 All outputs SHALL be registered or decoded from registered state only; no combinational path from ui_in to uo_out.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, vec=0, cnt=0, mask=0, count=0, pass=0, done=0, a=b=0, and clear the synchronizer flops.
REQ-024 Reset SHALL set start_prev=1, so a start held high through reset release does not trigger a run.
REQ-025 Reset mid-run SHALL abandon the run with no partial result retained; uio_oe SHALL stay 8'h0F throughout reset.

Verification
REQ-026 Loopback AND model, func=00, settle=00 (S=3): start pulse -> a/b step 00,01,10,11 each for 4 cycles; done at cycle 16; pass=1, mask=0000, count=0.
REQ-027 c_in stuck 0, func=00: -> mask=1000, count=1, pass=0.
REQ-028 OR model on c_in, func=00, settle=11 (S=6): -> mask=0110, count=2, pass=0, done at cycle 28.
REQ-029 NAND model, func=11: -> pass=1. Then XOR model, func=10, new start edge: mask cleared at restart; -> pass=1.
REQ-030 rst_n low during DRIVE of vec 2 -> all uo_out=0, uio_out=0 asynchronously. Start held high across release -> no run. Start low then high -> full run from vec 0.
REQ-031 Second start edge mid-run and settle/func changes mid-run -> ignored; timing and result identical to an undisturbed run.
